store_write_buffer: RTL and testbench
=====================================

# store_write_buffer

Posted-write buffer between the store formatter and data memory. Each cycle it accepts one formatted store (address, zero-extended data, byte-enable mask) and queues it in a small FIFO. It drains the queue to the data-memory write port through a request/acknowledge handshake, and flags loads that hit a still-pending store so the core can stall.

## Interface
Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- ADDR_W, 64, width of the byte address.

Ports:
- iCLK  input  1  clock; all state updates on the rising edge.
- iRST  input  1  asynchronous, active-high reset.
- iStoreValid  input  1  store request this cycle (MemWrite).
- iAddress  input  ADDR_W  store byte address.
- iData  input  64  formatted store data, lane-aligned by the upstream formatter.
- iByteEnable  input  8  byte-lane mask from the upstream formatter.
- oStoreReady  output  1  buffer can accept a store; equals !oFull.
- iLoadValid  input  1  load in progress this cycle.
- iLoadAddress  input  ADDR_W  load byte address.
- oLoadHazard  output  1  load overlaps a queued store; the core must stall.
- oMemWrite  output  1  write request to data memory.
- oMemAddress  output  ADDR_W  address of the head entry.
- oMemData  output  64  data of the head entry.
- oMemByteEnable  output  8  byte-enable mask of the head entry.
- iMemAck  input  1  memory accepted the presented write.
- oCount  output  $clog2(DEPTH)+1  number of occupied entries.
- oEmpty  output  1  oCount == 0.
- oFull  output  1  oCount == DEPTH.

## Operation
- Storage: circular FIFO with write pointer, read pointer and occupancy counter. Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Enqueue:
  - Fires when iStoreValid && oStoreReady && iByteEnable != 0.
  - Writes {iAddress, iData, iByteEnable} at the write pointer.
  - Increments the write pointer.
- Null store: iStoreValid with iByteEnable == 0 (non-store opcode mask) is accepted and silently discarded. No entry is written and no counter changes.
- Store while full: iStoreValid with oStoreReady = 0 is not accepted. The core must hold the request; the buffer does not record it.
- Drain:
  - oMemWrite = !oEmpty.
  - oMemAddress, oMemData and oMemByteEnable show the head entry, forced to 0 when empty.
  - Dequeue fires when oMemWrite && iMemAck, which increments the read pointer.
  - iMemAck while oMemWrite = 0 is ignored.
- Counter: oCount_next = oCount + enq - deq. Enqueue and dequeue in the same cycle leave the count unchanged.
- Full plus ack: oStoreReady is !oFull from registered state. A store presented while full is refused even if iMemAck retires an entry in the same cycle.
- Hazard: oLoadHazard = iLoadValid && (some occupied entry has addr[ADDR_W-1:3] == iLoadAddress[ADDR_W-1:3]).
  - Matching is at doubleword granularity and ignores byte enables.
  - The check covers the head entry until the edge at which it is acknowledged.
  - The check does not include a store arriving in the same cycle; a single-cycle core never issues a load and a store together.
- Ordering: strictly FIFO. Writes leave in acceptance order; no coalescing.

## Timing
- Reset (asynchronous, takes effect immediately):
  - Pointers and count go to 0.
  - oEmpty = 1, oFull = 0, oStoreReady = 1.
  - oMemWrite = 0; oMemAddress, oMemData and oMemByteEnable = 0.
  - oLoadHazard = 0.
  - Queued and in-flight writes are dropped. Reset during a write deasserts oMemWrite without waiting for iMemAck.
- Enqueue-to-request latency: a store accepted at edge t produces oMemWrite = 1 with its fields in the cycle after t when the buffer was empty. There is no combinational bypass.
- Handshake:
  - oMemWrite and the head fields stay stable until the edge at which iMemAck is sampled high.
  - Back-to-back acks retire one entry per cycle; the next head appears in the following cycle.
- oLoadHazard, oStoreReady, oFull, oEmpty and oCount are valid from registered state in the same cycle. Only oLoadHazard also depends on iLoadValid and iLoadAddress.
- Throughput: one enqueue and one dequeue per cycle sustained.

## Test plan
- Reset and idle:
  - Stimulus: assert iRST mid-cycle with 2 entries queued.
  - Required: oMemWrite drops immediately; oCount = 0, oEmpty = 1, all head fields 0; no write issues after iRST releases.
- Single store:
  - Stimulus: store addr 0x100, data 0xAB, BE 0x01 into the empty buffer, with iMemAck held low for 3 cycles then pulsed.
  - Required: oMemWrite = 1 from the next cycle, fields stable for 4 cycles; oEmpty = 1 after the ack edge.
- Fill and overflow:
  - Stimulus: 5 stores at addrs 0x0, 0x8, 0x10, 0x18, 0x20, no ack; then ack together with the 5th store held.
  - Required: oFull and oStoreReady = 0 after the 4th store; the 5th is refused in the ack cycle and accepted in the next cycle.
  - Required: drain order is 0x0, 0x8, 0x10, 0x18, 0x20, and the read pointer wraps correctly.
- Null store: stimulus iStoreValid with BE 0x00 → required oCount unchanged and oMemWrite stays 0.
- Load hazard:
  - Stimulus: store addr 0x208 queued, then loads at 0x20C and 0x210.
  - Required: hazard = 1 for 0x20C and 0 for 0x210; hazard clears in the cycle after the 0x208 entry is acknowledged.
- Simultaneous enqueue and dequeue: stimulus at oCount = 2, store and ack in the same cycle → required oCount stays 2 and the next head is the second-oldest entry.

Source files
------------

// File: rtl/store_write_buffer.sv
// Posted-write buffer: queues formatted stores in a circular FIFO, drains them to
// data memory over a request/ack handshake and flags loads that hit a pending store.
module store_write_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 64
) (
  input  logic                     iCLK,
  input  logic                     iRST,
  input  logic                     iStoreValid,
  input  logic [ADDR_W-1:0]        iAddress,
  input  logic [63:0]              iData,
  input  logic [7:0]               iByteEnable,
  output logic                     oStoreReady,
  input  logic                     iLoadValid,
  input  logic [ADDR_W-1:0]        iLoadAddress,
  output logic                     oLoadHazard,
  output logic                     oMemWrite,
  output logic [ADDR_W-1:0]        oMemAddress,
  output logic [63:0]              oMemData,
  output logic [7:0]               oMemByteEnable,
  input  logic                     iMemAck,
  output logic [$clog2(DEPTH):0]   oCount,
  output logic                     oEmpty,
  output logic                     oFull
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [ADDR_W-1:0] addr_mem_q [DEPTH];
  logic [63:0]       data_mem_q [DEPTH];
  logic [7:0]        be_mem_q   [DEPTH];

  logic enq;
  logic deq;
  logic hit;
  logic [PTR_W-1:0] offset;

  // Status, handshake and pointer/count next-state
  always_comb begin
    oEmpty      = (count_q == '0);
    oFull       = (count_q == CNT_W'(DEPTH));
    oStoreReady = !oFull;
    oMemWrite   = !oEmpty;
    oCount      = count_q;

    enq = iStoreValid && !oFull && (iByteEnable != 8'h00);
    deq = oMemWrite && iMemAck;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
  end

  // Head entry presented to memory, zeroed while nothing is queued
  always_comb begin
    oMemAddress    = '0;
    oMemData       = '0;
    oMemByteEnable = '0;
    if (!oEmpty) begin
      oMemAddress    = addr_mem_q[rd_ptr_q];
      oMemData       = data_mem_q[rd_ptr_q];
      oMemByteEnable = be_mem_q[rd_ptr_q];
    end
  end

  // Doubleword-granular match against occupied slots only (slot distance from head < count)
  always_comb begin
    hit    = 1'b0;
    offset = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - rd_ptr_q;
      if ((CNT_W'(offset) < count_q) &&
          (addr_mem_q[i][ADDR_W-1:3] == iLoadAddress[ADDR_W-1:3]))
        hit = 1'b1;
    end
    oLoadHazard = iLoadValid && hit;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy gates every read of it
  always_ff @(posedge iCLK) begin
    if (enq) begin
      addr_mem_q[wr_ptr_q] <= iAddress;
      data_mem_q[wr_ptr_q] <= iData;
      be_mem_q[wr_ptr_q]   <= iByteEnable;
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_store_write_buffer;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 64;

  logic               iCLK;
  logic               iRST;
  logic               iStoreValid;
  logic [ADDR_W-1:0]  iAddress;
  logic [63:0]        iData;
  logic [7:0]         iByteEnable;
  logic               oStoreReady;
  logic               iLoadValid;
  logic [ADDR_W-1:0]  iLoadAddress;
  logic               oLoadHazard;
  logic               oMemWrite;
  logic [ADDR_W-1:0]  oMemAddress;
  logic [63:0]        oMemData;
  logic [7:0]         oMemByteEnable;
  logic               iMemAck;
  logic [$clog2(DEPTH):0] oCount;
  logic               oEmpty;
  logic               oFull;

  store_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iStoreValid(iStoreValid), .iAddress(iAddress), .iData(iData),
    .iByteEnable(iByteEnable), .oStoreReady(oStoreReady),
    .iLoadValid(iLoadValid), .iLoadAddress(iLoadAddress), .oLoadHazard(oLoadHazard),
    .oMemWrite(oMemWrite), .oMemAddress(oMemAddress), .oMemData(oMemData),
    .oMemByteEnable(oMemByteEnable), .iMemAck(iMemAck),
    .oCount(oCount), .oEmpty(oEmpty), .oFull(oFull)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] d;
    logic [7:0]  be;
  } ent_t;

  ent_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model's current view
  task automatic check_outputs();
    logic exp_haz;
    ent_t head;
    exp_haz = 1'b0;
    if (iLoadValid)
      foreach (q[i])
        if (q[i].a[63:3] == iLoadAddress[63:3]) exp_haz = 1'b1;
    head = (q.size() > 0) ? q[0] : '0;
    check("count",  64'(oCount),      64'(q.size()));
    check("empty",  64'(oEmpty),      64'(q.size() == 0));
    check("full",   64'(oFull),       64'(q.size() == DEPTH));
    check("ready",  64'(oStoreReady), 64'(q.size() != DEPTH));
    check("memwr",  64'(oMemWrite),   64'(q.size() != 0));
    check("maddr",  oMemAddress,      head.a);
    check("mdata",  oMemData,         head.d);
    check("mbe",    64'(oMemByteEnable), 64'(head.be));
    check("hazard", 64'(oLoadHazard), 64'(exp_haz));
  endtask

  // One cycle: drive at negedge, check, then advance the model at posedge
  task automatic cyc(input logic sv, input logic [63:0] a, input logic [63:0] d,
                     input logic [7:0] be, input logic lv, input logic [63:0] la,
                     input logic ack);
    logic acc, dq;
    ent_t e;
    iStoreValid  = sv;
    iAddress     = a;
    iData        = d;
    iByteEnable  = be;
    iLoadValid   = lv;
    iLoadAddress = la;
    iMemAck      = ack;
    #1;
    check_outputs();
    @(posedge iCLK);
    acc = sv && (q.size() < DEPTH) && (be != 8'h00);
    dq  = (q.size() > 0) && ack;
    if (dq) void'(q.pop_front());
    if (acc) begin
      e.a = a; e.d = d; e.be = be;
      q.push_back(e);
    end
    @(negedge iCLK);
  endtask

  task automatic idle(input logic ack);
    cyc(1'b0, 64'h0, 64'h0, 8'h00, 1'b0, 64'h0, ack);
  endtask

  task automatic store(input logic [63:0] a, input logic [63:0] d, input logic [7:0] be,
                       input logic ack);
    cyc(1'b1, a, d, be, 1'b0, 64'h0, ack);
  endtask

  task automatic load(input logic [63:0] la, input logic ack);
    cyc(1'b0, 64'h0, 64'h0, 8'h00, 1'b1, la, ack);
  endtask

  // Reset asserted between edges with the inputs idle
  task automatic mid_reset();
    iStoreValid = 1'b0; iByteEnable = 8'h00; iLoadValid = 1'b0; iMemAck = 1'b0;
    iRST = 1'b1;
    #1;
    q.delete();
    check("rst_memwr_now", 64'(oMemWrite), 64'h0);
    check_outputs();
    @(posedge iCLK);
    @(negedge iCLK);
    check_outputs();
    iRST = 1'b0;
  endtask

  initial begin
    logic [63:0] ra, rl;
    logic [7:0]  rbe;
    iRST = 1'b1;
    iStoreValid = 1'b0; iAddress = '0; iData = '0; iByteEnable = '0;
    iLoadValid = 1'b0; iLoadAddress = '0; iMemAck = 1'b0;
    @(negedge iCLK);
    check_outputs();
    @(negedge iCLK);
    iRST = 1'b0;

    // Single store, ack withheld three cycles
    store(64'h100, 64'hAB, 8'h01, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b0);
    idle(1'b1);
    idle(1'b0);

    // Fill, refused fifth store during ack, then accepted
    store(64'h00, 64'h11, 8'hFF, 1'b0);
    store(64'h08, 64'h22, 8'h0F, 1'b0);
    store(64'h10, 64'h33, 8'hF0, 1'b0);
    store(64'h18, 64'h44, 8'h03, 1'b0);
    store(64'h20, 64'h55, 8'h80, 1'b1);
    check("after_full_ack_cnt", 64'(oCount), 64'd3);
    store(64'h20, 64'h55, 8'h80, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    idle(1'b0);

    // Null store is discarded
    store(64'h40, 64'h99, 8'h00, 1'b0);
    idle(1'b0);

    // Load hazard at doubleword granularity
    store(64'h208, 64'h77, 8'h10, 1'b0);
    load(64'h20C, 1'b0);
    load(64'h210, 1'b0);
    load(64'h20C, 1'b1);
    load(64'h20C, 1'b0);

    // Simultaneous enqueue and dequeue at count 2
    store(64'h300, 64'h1, 8'h01, 1'b0);
    store(64'h308, 64'h2, 8'h02, 1'b0);
    store(64'h310, 64'h3, 8'h04, 1'b1);
    check("simul_head", oMemAddress, 64'h308);
    idle(1'b0);

    // Reset with two entries queued, then stay quiet
    mid_reset();
    for (int i = 0; i < 3; i++) idle(1'b1);
    store(64'h500, 64'h5, 8'h01, 1'b0);
    store(64'h508, 64'h6, 8'h01, 1'b0);
    mid_reset();
    for (int i = 0; i < 3; i++) idle(1'b0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      ra  = {($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'h0, 32'($urandom_range(0, 63))};
      rl  = {ra[63:32], 32'($urandom_range(0, 63))};
      rbe = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      if ($urandom_range(0, 499) == 0) mid_reset();
      cyc(1'($urandom_range(0, 1)), ra, {32'($urandom), 32'($urandom)}, rbe,
          1'($urandom_range(0, 1)), rl, 1'($urandom_range(0, 2) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
